// File: rtl/spi_master_arbiter_pkg.sv
// rtl/spi_master_arbiter_pkg.sv - shared state encoding, defaults and width helper
package spi_master_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_XFER  = 3'd3,
        ST_DONE  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    localparam int SS_GAP_DEFAULT  = 2;
    localparam int TIMEOUT_DEFAULT = 1023;

    // Bits needed to hold 0..n-1, never fewer than one.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/spi_master_arbiter_rr_arbiter.sv
// rtl/spi_master_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr
module spi_master_arbiter_rr_arbiter
    import spi_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = clog2(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               any,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx
);

    logic [IDW-1:0] cand;

    always_comb begin
        any   = 1'b0;
        grant = '0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin sharing of one SPI master between requesters
module spi_master_arbiter
    import spi_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int SS_GAP  = SS_GAP_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
)(
    input  logic                        clk_fpga,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   tx_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          done,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        timeout_err,
    output logic [$clog2(NUM_REQ)-1:0]  active_id,
    output logic [DATA_W-1:0]           m_data,
    output logic                        ss,
    input  logic                        busy_m,
    input  logic [DATA_W-1:0]           m_rece
);

    localparam int IDW     = $clog2(NUM_REQ);
    localparam int CNT_MAX = (TIMEOUT > SS_GAP) ? TIMEOUT : SS_GAP;
    localparam int CW      = clog2(CNT_MAX + 1);

    // cnt holds the number of cycles already spent in the current state.
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(SS_GAP - 1);

    state_t               state;
    logic [IDW-1:0]       ptr;
    logic [CW-1:0]        cnt;
    logic                 arb_any;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDW-1:0]       arb_idx;
    logic [IDW-1:0]       ptr_next;

    spi_master_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req   (req),
        .ptr   (ptr),
        .any   (arb_any),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign ptr_next = (active_id == IDW'(NUM_REQ - 1)) ? '0 : active_id + 1'b1;

    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ss          <= 1'b1;
            gnt         <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            rx_data     <= '0;
            m_data      <= '0;
            active_id   <= '0;
            ptr         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt       <= arb_grant;
                        active_id <= arb_idx;
                        m_data    <= tx_data[int'(arb_idx)*DATA_W +: DATA_W];
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    ss    <= 1'b0;
                    cnt   <= '0;
                    state <= ST_START;
                end
                ST_START: begin
                    if (busy_m) begin
                        cnt   <= '0;
                        state <= ST_XFER;
                    end else if (cnt >= TO_LAST) begin
                        ss          <= 1'b1;
                        done        <= gnt;
                        timeout_err <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_XFER: begin
                    // Completion wins over a timeout landing on the same cycle.
                    if (!busy_m) begin
                        ss      <= 1'b1;
                        done    <= gnt;
                        rx_data <= m_rece;
                        state   <= ST_DONE;
                    end else if (cnt >= TO_LAST) begin
                        ss          <= 1'b1;
                        done        <= gnt;
                        timeout_err <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done        <= '0;
                    timeout_err <= 1'b0;
                    gnt         <= '0;
                    ptr         <= ptr_next;
                    cnt         <= '0;
                    state       <= ST_GAP;
                end
                ST_GAP: begin
                    if (cnt >= GAP_LAST) state <= ST_IDLE;
                    else                 cnt   <= cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - self-checking bench for spi_master_arbiter
module tb_spi_master_arbiter;

    localparam int N       = 4;
    localparam int DW      = 8;
    localparam int SS_GAP  = 2;
    localparam int TIMEOUT = 40;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N*DW-1:0] tx_data;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic [DW-1:0] rx_data;
    logic          timeout_err;
    logic [1:0]    active_id;
    logic [DW-1:0] m_data;
    logic          ss;
    logic          busy_m;
    logic [DW-1:0] m_rece;
    logic [DW-1:0] tx_word [N];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int n_done = 0;
    int busy_fall_cyc = 0;
    int start_dly = 1;
    int xfer_len = 3;
    bit hang_start = 1'b0;
    bit hang_busy = 1'b0;
    bit rand_mode = 1'b0;
    bit use_fixed = 1'b1;
    bit m_sent_valid = 1'b0;
    logic [DW-1:0] fixed_resp = 8'h00;
    logic [DW-1:0] m_resp = 8'h00;
    logic [DW-1:0] m_sent = 8'h00;

    typedef struct {
        logic [N-1:0]  mask;
        logic [DW-1:0] resp;
        int            exp_w;
    } vec_t;

    vec_t tbl [8];
    int   exp_order [5];

    always #5 clk = ~clk;

    always_comb begin
        tx_data = '0;
        for (int i = 0; i < N; i++) tx_data[i*DW +: DW] = tx_word[i];
    end

    spi_master_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .SS_GAP  (SS_GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_fpga    (clk),
        .rst_n       (rst_n),
        .req         (req),
        .tx_data     (tx_data),
        .gnt         (gnt),
        .done        (done),
        .rx_data     (rx_data),
        .timeout_err (timeout_err),
        .active_id   (active_id),
        .m_data      (m_data),
        .ss          (ss),
        .busy_m      (busy_m),
        .m_rece      (m_rece)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Winner is the requester with the smallest forward distance from the pointer.
    function automatic int rr_model(input logic [N-1:0] r, input int p);
        int best, bestd, d;
        best = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            d = (i - p + N) % N;
            if (r[i] && d < bestd) begin
                best = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Stand-in for the SPI master: busy after a delay while selected, then returns a word.
    initial begin
        int m_ph, m_cnt;
        busy_m = 1'b0;
        m_rece = '0;
        m_ph = 0;
        m_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_m = 1'b0;
                m_ph = 0;
            end else begin
                case (m_ph)
                    0: if (!ss) begin
                        if (rand_mode) begin
                            start_dly = $urandom_range(0, 3);
                            xfer_len  = $urandom_range(0, 6);
                            hang_busy = ($urandom_range(0, 7) == 0);
                        end
                        m_cnt = start_dly;
                        m_ph = hang_start ? 3 : 1;
                    end
                    1: if (m_cnt == 0) begin
                        busy_m = 1'b1;
                        m_sent = m_data;
                        m_sent_valid = 1'b1;
                        m_cnt = xfer_len;
                        m_ph = 2;
                    end else m_cnt--;
                    2: if (ss) begin
                        busy_m = 1'b0;
                        m_ph = 0;
                    end else if (m_cnt == 0) begin
                        if (!hang_busy) begin
                            m_resp = use_fixed ? fixed_resp : 8'($urandom);
                            m_rece = m_resp;
                            busy_m = 1'b0;
                            busy_fall_cyc = cyc;
                            m_ph = 3;
                        end
                    end else m_cnt--;
                    default: if (ss) m_ph = 0;
                endcase
            end
        end
    end

    // Transaction-level reference: grant choice, data, completion, pointer and ss-gap rules.
    initial begin
        int mptr, exp_w, ss_hi;
        bit in_txn, exp_abort;
        logic [DW-1:0] model_rx, exp_word, exp_rx;
        mptr = 0;
        exp_w = 0;
        ss_hi = 1000;
        in_txn = 1'b0;
        model_rx = '0;
        exp_word = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mptr = 0;
                in_txn = 1'b0;
                model_rx = '0;
                ss_hi = 1000;
            end else begin
                if (!in_txn && gnt != '0) begin
                    exp_w = rr_model(req, mptr);
                    exp_word = (exp_w >= 0) ? tx_word[exp_w] : 8'h00;
                    chk("mon_grant", gnt, 1 << exp_w);
                    chk("mon_active_id", active_id, exp_w);
                    chk("mon_m_data", m_data, exp_word);
                    m_sent_valid = 1'b0;
                    in_txn = 1'b1;
                end
                if (done != '0) begin
                    n_done++;
                    exp_abort = hang_start || hang_busy;
                    exp_rx = exp_abort ? model_rx : m_resp;
                    chk("mon_done", done, in_txn ? (1 << exp_w) : 0);
                    chk("mon_timeout_err", timeout_err, exp_abort);
                    chk("mon_rx_data", rx_data, exp_rx);
                    chk("mon_m_data_held", m_data, exp_word);
                    if (!hang_start) chk("mon_spi_word", {m_sent_valid, m_sent}, {1'b1, exp_word});
                    model_rx = exp_rx;
                    mptr = (exp_w + 1) % N;
                    in_txn = 1'b0;
                end
                if (ss) ss_hi++;
                else begin
                    if (ss_hi > 0) chk("mon_ss_gap", (ss_hi >= SS_GAP + 2), 1);
                    ss_hi = 0;
                end
            end
        end
    end

    task automatic wait_done(input string name, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (done == '0 && n < 4 * TIMEOUT);
        if (done == '0) chk({name, "_no_done"}, 0, 1);
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!busy_m && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!busy_m) chk({name, "_no_busy"}, 0, 1);
    endtask

    task automatic wait_ss_low(input string name);
        int n;
        n = 0;
        while (ss && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (ss) chk({name, "_no_select"}, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = '0;
        hang_start = 1'b0;
        hang_busy = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n, base;
        tbl[0] = '{4'b0001, 8'h11, 0};
        tbl[1] = '{4'b0101, 8'h22, 2};
        tbl[2] = '{4'b0011, 8'h33, 0};
        tbl[3] = '{4'b1000, 8'h44, 3};
        tbl[4] = '{4'b1110, 8'h55, 1};
        tbl[5] = '{4'b1111, 8'h66, 2};
        tbl[6] = '{4'b0110, 8'h77, 1};
        tbl[7] = '{4'b0001, 8'h88, 0};
        exp_order = '{0, 1, 2, 3, 0};

        rst_n = 1'b1;
        req = '0;
        for (int i = 0; i < N; i++) tx_word[i] = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ss", ss, 1);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_active_id", active_id, 0);
        rst_n = 1'b1;

        // Single request: select latency and busy-fall-to-done latency.
        @(negedge clk);
        tx_word[0] = 8'h45;
        fixed_resp = 8'h35;
        req = 4'b0001;
        @(posedge clk); #1;
        chk("setup_ss_high", ss, 1);
        chk("setup_gnt", gnt, 4'b0001);
        @(posedge clk); #1;
        chk("ss_low_latency", ss, 0);
        wait_done("single", n);
        chk("single_done", done, 4'b0001);
        chk("single_rx", rx_data, 8'h35);
        chk("single_terr", timeout_err, 0);
        chk("single_sent", m_sent, 8'h45);
        chk("busy_to_done", cyc - busy_fall_cyc, 1);
        @(negedge clk);
        req = '0;
        repeat (6) @(negedge clk);

        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) tx_word[i] = 8'(8'hA0 + k * 4 + i);
            fixed_resp = tbl[k].resp;
            req = tbl[k].mask;
            wait_done($sformatf("tbl%0d", k), n);
            chk($sformatf("tbl%0d_done", k), done, 1 << tbl[k].exp_w);
            chk($sformatf("tbl%0d_rx", k), rx_data, tbl[k].resp);
            @(negedge clk);
            req = '0;
            repeat (5) @(negedge clk);
        end

        // Two simultaneous requests, then confirm the pointer landed on 3.
        do_reset();
        @(negedge clk);
        tx_word[0] = 8'hF4;
        tx_word[2] = 8'h20;
        fixed_resp = 8'h5A;
        req = 4'b0101;
        wait_done("pair_first", n);
        chk("pair_first_done", done, 4'b0001);
        @(negedge clk);
        req[0] = 1'b0;
        wait_done("pair_second", n);
        chk("pair_second_done", done, 4'b0100);
        @(negedge clk);
        req = 4'b1011;
        wait_done("ptr_after_pair", n);
        chk("ptr_after_pair_done", done, 4'b1000);
        @(negedge clk);
        req = '0;
        repeat (5) @(negedge clk);

        // All requests held continuously.
        do_reset();
        @(negedge clk);
        fixed_resp = 8'h3C;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done($sformatf("rr%0d", k), n);
            chk($sformatf("rr_order%0d", k), active_id, exp_order[k]);
        end
        @(negedge clk);
        req = '0;
        repeat (5) @(negedge clk);

        // Master never goes busy: START timeout.
        @(negedge clk);
        hang_start = 1'b1;
        req = 4'b0010;
        wait_ss_low("start_to");
        wait_done("start_to", n);
        chk("start_to_cycles", n, TIMEOUT);
        chk("start_to_terr", timeout_err, 1);
        chk("start_to_done", done, 4'b0010);
        chk("start_to_rx_held", rx_data, 8'h3C);
        chk("start_to_ss", ss, 1);
        @(negedge clk);
        req = '0;
        hang_start = 1'b0;
        repeat (5) @(negedge clk);

        // Master stuck busy: XFER timeout.
        @(negedge clk);
        hang_busy = 1'b1;
        req = 4'b0100;
        wait_done("xfer_to", n);
        chk("xfer_to_terr", timeout_err, 1);
        chk("xfer_to_done", done, 4'b0100);
        chk("xfer_to_rx_held", rx_data, 8'h3C);
        @(negedge clk);
        req = '0;
        hang_busy = 1'b0;
        repeat (5) @(negedge clk);

        // Reset in the middle of a transfer.
        @(negedge clk);
        xfer_len = 20;
        req = 4'b0001;
        wait_busy("rst_mid");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ss", ss, 1);
        chk("rst_mid_gnt", gnt, 0);
        chk("rst_mid_done", done, 0);
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer_len = 3;
        fixed_resp = 8'hA7;
        tx_word[1] = 8'h6E;
        req = 4'b0010;
        wait_done("post_rst", n);
        chk("post_rst_done", done, 4'b0010);
        chk("post_rst_rx", rx_data, 8'hA7);
        chk("post_rst_sent", m_sent, 8'h6E);
        @(negedge clk);
        req = '0;
        repeat (5) @(negedge clk);

        // Request withdrawn during XFER still completes; pointer then sits at 2.
        @(negedge clk);
        xfer_len = 8;
        req = 4'b0010;
        wait_busy("drop");
        @(negedge clk);
        req = '0;
        wait_done("drop", n);
        chk("drop_done", done, 4'b0010);
        @(negedge clk);
        req = 4'b1011;
        wait_done("after_drop", n);
        chk("after_drop_done", done, 4'b1000);
        @(negedge clk);
        req = '0;
        xfer_len = 3;
        repeat (5) @(negedge clk);

        // Randomized requesters and master timing against the reference model.
        rand_mode = 1'b1;
        use_fixed = 1'b0;
        base = n_done;
        for (int c = 0; c < 8000 && (n_done - base) < 40; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req[i] && done[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    tx_word[i] = 8'($urandom);
                    req[i] = 1'b1;
                end
            end
        end
        chk("rand_txn_count", ((n_done - base) >= 40), 1);
        @(negedge clk);
        req = '0;
        repeat (4 * TIMEOUT) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
